// File: rtl/poker_pkg.sv
// Shared types and constants for the poker hand classifier pipeline.
// A card is {suit, rank}; rank 1 is the ace and rank 13 is the king.
package poker_pkg;

    localparam int unsigned SUIT_W       = 2;
    localparam int unsigned RANK_W       = 4;
    localparam int unsigned CARD_W       = SUIT_W + RANK_W;
    localparam int unsigned RANK_MIN_DEF = 1;
    localparam int unsigned RANK_MAX_DEF = 13;
    localparam int unsigned HAND_SIZE    = 5;

    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_RANK = 2'd1,
        ERR_DUP  = 2'd2
    } err_code_e;

    typedef enum logic {
        StCollect = 1'b0,
        StPresent = 1'b1
    } state_e;

endpackage

// File: rtl/poker_hand_loader_if.sv
// Card intake and hand presentation bundle between the card source, the loader and the
// classifier. The master side offers cards and takes hands; the slave side is the loader.
interface poker_hand_loader_if #(
    parameter int unsigned HCNT_W = 8
);
    import poker_pkg::*;

    card_t             card_in;
    logic              card_valid;
    logic              card_ready;
    logic              flush;
    card_t             i0;
    card_t             i1;
    card_t             i2;
    card_t             i3;
    card_t             i4;
    logic              hand_valid;
    logic              hand_ready;
    logic [2:0]        count;
    logic              err;
    logic [1:0]        err_code;
    logic [HCNT_W-1:0] hands_done;

    modport master (
        output card_in, card_valid, flush, hand_ready,
        input  card_ready, i0, i1, i2, i3, i4, hand_valid, count, err, err_code, hands_done
    );

    modport slave (
        input  card_in, card_valid, flush, hand_ready,
        output card_ready, i0, i1, i2, i3, i4, hand_valid, count, err, err_code, hands_done
    );

endinterface

// File: rtl/poker_card_check.sv
// Combinational legality check of an offered card: rank range and duplicate against the
// slots already filled (only indices below count are live).
module poker_card_check
    import poker_pkg::*;
#(
    parameter int unsigned RANK_MIN = RANK_MIN_DEF,
    parameter int unsigned RANK_MAX = RANK_MAX_DEF
) (
    input  card_t      card,
    input  card_t      slots [HAND_SIZE],
    input  logic [2:0] count,
    output logic       rank_ok,
    output logic       dup
);

    logic [RANK_W-1:0] rank;

    assign rank    = card[RANK_W-1:0];
    assign rank_ok = (rank >= RANK_W'(RANK_MIN)) && (rank <= RANK_W'(RANK_MAX));

    // Stale slot contents from earlier hands must not count as duplicates.
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < HAND_SIZE; k++) begin
            if ((3'(k) < count) && (slots[k] == card)) begin
                dup = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poker_hand_loader.sv
// Collects five legal, distinct cards into slots i0..i4 and presents them as one hand.
// Priority at each edge: reset > flush > consume > offer.
module poker_hand_loader
    import poker_pkg::*;
#(
    parameter int unsigned RANK_MIN = RANK_MIN_DEF,
    parameter int unsigned RANK_MAX = RANK_MAX_DEF,
    parameter int unsigned HCNT_W   = 8
) (
    input logic                clk,
    input logic                reset,
    poker_hand_loader_if.slave bus
);

    state_e            state_q;
    logic [2:0]        count_q;
    card_t             slots_q [HAND_SIZE];
    logic              err_q;
    err_code_e         err_code_q;
    logic [HCNT_W-1:0] hands_q;
    logic              rank_ok;
    logic              dup;

    poker_card_check #(
        .RANK_MIN (RANK_MIN),
        .RANK_MAX (RANK_MAX)
    ) u_check (
        .card    (bus.card_in),
        .slots   (slots_q),
        .count   (count_q),
        .rank_ok (rank_ok),
        .dup     (dup)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCollect;
            count_q    <= 3'd0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            hands_q    <= '0;
            for (int k = 0; k < HAND_SIZE; k++) begin
                slots_q[k] <= '0;
            end
        end else if (bus.flush) begin
            // Slots and the last error code survive a flush on purpose.
            state_q <= StCollect;
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StCollect: begin
                    if (bus.card_valid) begin
                        if (!rank_ok) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RANK;
                        end else if (dup) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_DUP;
                        end else begin
                            for (int k = 0; k < HAND_SIZE; k++) begin
                                if (count_q == 3'(k)) begin
                                    slots_q[k] <= bus.card_in;
                                end
                            end
                            count_q    <= count_q + 3'd1;
                            err_code_q <= ERR_NONE;
                            if (count_q == 3'(HAND_SIZE - 1)) begin
                                state_q <= StPresent;
                            end
                        end
                    end
                end
                StPresent: begin
                    if (bus.hand_ready) begin
                        state_q <= StCollect;
                        count_q <= 3'd0;
                        hands_q <= hands_q + HCNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.card_ready = (state_q == StCollect);
    assign bus.hand_valid = (state_q == StPresent);
    assign bus.i0         = slots_q[0];
    assign bus.i1         = slots_q[1];
    assign bus.i2         = slots_q[2];
    assign bus.i3         = slots_q[3];
    assign bus.i4         = slots_q[4];
    assign bus.count      = count_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.hands_done = hands_q;

endmodule

// File: tb/tb_poker_hand_loader.sv
// Scoreboard bench for poker_hand_loader: a queue-based card/hand model predicts every cycle;
// completed hands are queued and checked by a separate monitor when they leave the loader.
module tb_poker_hand_loader;
    import poker_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    poker_hand_loader_if #(.HCNT_W(8)) bus ();

    poker_hand_loader #(
        .RANK_MIN (1),
        .RANK_MAX (13),
        .HCNT_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: the cards held, whether a hand is on offer, and counters.
    card_t        held [$];
    logic         m_present;
    int unsigned  m_hands;
    logic         m_err;
    logic [1:0]   m_code;
    logic [29:0]  hand_q [$];
    logic         checking = 1'b0;

    int unsigned  vectors    = 0;
    int unsigned  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_hand(input card_t c);
        foreach (held[k]) if (held[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic card_t rand_legal();
        int unsigned s = $urandom_range(0, 3);
        int unsigned r = $urandom_range(1, 13);
        return card_t'(s * 16 + r);
    endfunction

    // Effect of one clock edge given the inputs currently applied.
    task automatic model_edge();
        int unsigned r;
        logic [29:0] h;
        if (reset) begin
            held.delete();
            hand_q.delete();
            m_present = 1'b0;
            m_hands   = 0;
            m_err     = 1'b0;
            m_code    = 2'd0;
            checking  = 1'b1;
        end else if (bus.flush) begin
            held.delete();
            m_present = 1'b0;
            m_err     = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_present) begin
                if (bus.hand_ready) begin
                    m_present = 1'b0;
                    held.delete();
                    m_hands = (m_hands + 1) % 256;
                end
            end else if (bus.card_valid) begin
                r = int'(bus.card_in) % 16;
                if (r < 1 || r > 13) begin
                    m_err  = 1'b1;
                    m_code = 2'd1;
                end else if (in_hand(bus.card_in)) begin
                    m_err  = 1'b1;
                    m_code = 2'd2;
                end else begin
                    held.push_back(bus.card_in);
                    m_code = 2'd0;
                    if (held.size() == 5) begin
                        m_present = 1'b1;
                        h = {held[4], held[3], held[2], held[1], held[0]};
                        hand_q.push_back(h);
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic v, input card_t c, input logic f, input logic hr);
        bus.card_valid = v;
        bus.card_in    = c;
        bus.flush      = f;
        bus.hand_ready = hr;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 6'h00, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Five fresh legal cards with random gaps, then the hand is consumed (or left presented).
    task automatic play_hand(input bit consume);
        card_t c;
        int    got = 0;
        while (got < 5) begin
            c = rand_legal();
            if (!in_hand(c)) begin
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 6'h00, 1'b0, 1'($urandom_range(0, 1)));
                cyc(1'b1, c, 1'b0, 1'($urandom_range(0, 1)));
                got++;
            end
        end
        repeat ($urandom_range(0, 2)) cyc(1'($urandom_range(0, 1)), rand_legal(), 1'b0, 1'b0);
        if (consume) cyc(1'($urandom_range(0, 1)), rand_legal(), 1'b0, 1'b1);
    endtask

    // Monitor: compares visible state every cycle and pops a hand whenever one leaves.
    initial begin
        logic [29:0] h;
        forever begin
            @(negedge clk);
            if (checking) begin
                check("count", 32'(bus.count), 32'(held.size()));
                check("hand_valid", 32'(bus.hand_valid), 32'(m_present));
                check("card_ready", 32'(bus.card_ready), 32'(!m_present));
                check("err", 32'(bus.err), 32'(m_err));
                check("err_code", 32'(bus.err_code), 32'(m_code));
                check("hands_done", 32'(bus.hands_done), m_hands);
                if (bus.hand_valid && !reset && (bus.flush || bus.hand_ready)) begin
                    if (hand_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL hand_pop: hand left the loader, expected none at %0t",
                                 $time);
                    end else begin
                        h = hand_q.pop_front();
                        check("i0", 32'(bus.i0), 32'(h[5:0]));
                        check("i1", 32'(bus.i1), 32'(h[11:6]));
                        check("i2", 32'(bus.i2), 32'(h[17:12]));
                        check("i3", 32'(bus.i3), 32'(h[23:18]));
                        check("i4", 32'(bus.i4), 32'(h[29:24]));
                    end
                end
            end
        end
    end

    initial begin
        card_t t1 [5] = '{6'h01, 6'h12, 6'h23, 6'h34, 6'h05};
        card_t t2 [3] = '{6'h00, 6'h0E, 6'h3F};
        card_t c;
        int    roll;

        reset          = 1'b1;
        bus.card_valid = 1'b0;
        bus.card_in    = 6'h00;
        bus.flush      = 1'b0;
        bus.hand_ready = 1'b0;
        cyc(1'b0, 6'h00, 1'b0, 1'b0);
        do_reset();

        // Back-to-back hand, held while hand_ready stays low, then consumed.
        foreach (t1[k]) cyc(1'b1, t1[k], 1'b0, 1'b0);
        cyc(1'b1, 6'h06, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0);
        cyc(1'b1, 6'h07, 1'b0, 1'b1);

        // Illegal ranks.
        foreach (t2[k]) cyc(1'b1, t2[k], 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0);

        // Duplicate, then same rank in another suit, then flush with an offer alongside.
        cyc(1'b1, 6'h1D, 1'b0, 1'b0);
        cyc(1'b1, 6'h1D, 1'b0, 1'b0);
        cyc(1'b1, 6'h2D, 1'b0, 1'b0);
        cyc(1'b1, 6'h01, 1'b0, 1'b0);
        cyc(1'b1, 6'h02, 1'b1, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0);

        // Enough consumed hands to wrap the 8-bit counter.
        repeat (257) play_hand(1'b1);

        // Flush beats consume while presenting.
        play_hand(1'b0);
        cyc(1'b1, 6'h09, 1'b1, 1'b1);
        cyc(1'b0, 6'h00, 1'b0, 1'b0);

        // Reset mid-hand, then a fresh hand.
        foreach (t1[k]) if (k < 4) cyc(1'b1, t1[k], 1'b0, 1'b0);
        do_reset();
        cyc(1'b0, 6'h00, 1'b0, 1'b0);
        play_hand(1'b1);

        // Random traffic, including duplicates drawn from the cards held.
        repeat (3000) begin
            roll = int'($urandom_range(0, 9));
            if (roll < 6 || held.size() == 0) c = rand_legal();
            else if (roll < 8) c = held[$urandom_range(0, held.size() - 1)];
            else c = card_t'($urandom_range(0, 63));
            cyc(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 1)));
        end

        cyc(1'b0, 6'h00, 1'b1, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0);
        check("scoreboard_empty", 32'(hand_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
